// File: rtl/vertex_transform_stream_if.sv
// Stream-side bundle for vertex_transform_stream: matrix load, component input and result output.
// master = upstream/downstream environment, slave = transform engine.
interface vertex_transform_stream_if #(
    parameter int unsigned M   = 11,
    parameter int unsigned N   = 7,
    parameter int unsigned DIM = 4
);
    logic [DIM*DIM*(M+N)-1:0] matrix_in;
    logic                     matrix_load;
    logic signed [M+N-1:0]    in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [M-1:0]      out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     sat_flag;
    logic                     busy;

    modport master (
        output matrix_in, matrix_load, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, sat_flag, busy
    );

    modport slave (
        input  matrix_in, matrix_load, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, sat_flag, busy
    );
endinterface

// File: rtl/vertex_transform_stream.sv
// Streaming DIM x DIM fixed-point matrix-vector transform with one time-multiplexed MAC.
// Define VTX_ROUND_EN to round half toward +inf before the >>> N shift; default truncates.
module vertex_transform_stream #(
    parameter int unsigned M   = 11,
    parameter int unsigned N   = 7,
    parameter int unsigned DIM = 4
) (
    input logic                clk,
    input logic                reset,
    vertex_transform_stream_if.slave bus
);
    localparam int unsigned W  = M + N;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(DIM);
    localparam int unsigned AW = PW + CW;
    localparam int unsigned MW = DIM * DIM * W;
    localparam logic [CW-1:0] Last = CW'(DIM - 1);

    localparam logic signed [M-1:0] OutMax = {1'b0, {(M-1){1'b1}}};
    localparam logic signed [M-1:0] OutMin = {1'b1, {(M-1){1'b0}}};
`ifdef VTX_ROUND_EN
    localparam logic signed [AW-1:0] RndK = AW'(1) << (N - 1);
`else
    localparam logic signed [AW-1:0] RndK = '0;
`endif

    function automatic logic [MW-1:0] identity_mat();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < int'(DIM); i++) m[(i*int'(DIM)+i)*int'(W) +: W] = W'(1) << N;
        return m;
    endfunction

    localparam logic [MW-1:0] Ident = identity_mat();

    typedef enum logic [1:0] {StCollect, StCompute, StEmit} state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q, row_q, col_q;
    logic signed [W-1:0]    vec_q [DIM];
    logic signed [M-1:0]    res_q [DIM];
    logic                   sat_q [DIM];
    logic signed [AW-1:0]   acc_q;
    logic [MW-1:0]          active_q, shadow_q;
    logic                   pending_q;
    logic                   in_ready_q, out_valid_q, out_last_q, sat_flag_q, busy_q;
    logic signed [M-1:0]    out_data_q;

    logic signed [W-1:0]    coef, din;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   acc_base, acc_d, shifted;
    logic signed [M-1:0]    res_val;
    logic                   res_sat;
    logic [CW-1:0]          cnt_nxt;

    // MAC datapath; the final column of a row also produces the scaled, clamped result.
    always_comb begin
        coef     = $signed(active_q[(int'(row_q)*int'(DIM) + int'(col_q))*int'(W) +: W]);
        din      = vec_q[col_q];
        prod     = PW'(coef) * PW'(din);
        acc_base = acc_q;
        if (col_q == '0) acc_base = '0;
        acc_d    = acc_base + AW'(prod);
        shifted  = (acc_d + RndK) >>> N;
        res_sat  = 1'b0;
        res_val  = shifted[M-1:0];
        if (shifted > AW'(OutMax)) begin
            res_val = OutMax;
            res_sat = 1'b1;
        end else if (shifted < AW'(OutMin)) begin
            res_val = OutMin;
            res_sat = 1'b1;
        end
        cnt_nxt  = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            vec_q       <= '{default: '0};
            res_q       <= '{default: '0};
            sat_q       <= '{default: 1'b0};
            acc_q       <= '0;
            active_q    <= Ident;
            shadow_q    <= Ident;
            pending_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_flag_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            // Swap only at a vertex boundary; a coincident load stays pending for the next one.
            if (state_q == StCollect && cnt_q == '0 && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
            if (bus.matrix_load) begin
                shadow_q  <= bus.matrix_in;
                pending_q <= 1'b1;
            end

            unique case (state_q)
                StCollect: begin
                    if (bus.in_valid && in_ready_q) begin
                        vec_q[cnt_q] <= bus.in_data;
                        if (cnt_q == Last) begin
                            cnt_q      <= '0;
                            row_q      <= '0;
                            col_q      <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= StCompute;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                StCompute: begin
                    acc_q <= acc_d;
                    if (col_q == Last) begin
                        res_q[row_q] <= res_val;
                        sat_q[row_q] <= res_sat;
                        col_q        <= '0;
                        if (row_q == Last) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_q[0];
                            sat_flag_q  <= sat_q[0];
                            out_last_q  <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= StEmit;
                        end else begin
                            row_q <= row_q + CW'(1);
                        end
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        if (cnt_q == Last) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            sat_flag_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= StCollect;
                        end else begin
                            cnt_q      <= cnt_nxt;
                            out_data_q <= res_q[cnt_nxt];
                            sat_flag_q <= sat_q[cnt_nxt];
                            out_last_q <= (cnt_nxt == Last);
                        end
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.sat_flag  = sat_flag_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vertex_transform_stream.sv
// Scoreboard bench for vertex_transform_stream: directed vertices queue expected components,
// an independent monitor pops and compares on every output handshake.
module tb_vertex_transform_stream;
    localparam int M   = 11;
    localparam int N   = 7;
    localparam int DIM = 4;
    localparam int W   = M + N;

    typedef int vec_t[4];
    typedef bit flag_t[4];
    typedef struct packed {
        logic signed [M-1:0] d;
        logic                last;
        logic                sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    vertex_transform_stream_if #(.M(M), .N(N), .DIM(DIM)) bus ();

    vertex_transform_stream #(.M(M), .N(N), .DIM(DIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [DIM*DIM*W-1:0] diag_mat(input int d, input int off);
        logic [DIM*DIM*W-1:0] m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[(r*DIM+c)*W +: W] = W'((r == c) ? d : off);
        return m;
    endfunction

    task automatic load_mat(input logic [DIM*DIM*W-1:0] m);
        @(posedge clk); #1;
        bus.matrix_in   = m;
        bus.matrix_load = 1'b1;
        @(posedge clk); #1;
        bus.matrix_load = 1'b0;
    endtask

    task automatic send(input vec_t v, input vec_t e, input flag_t s, input bit push,
                        output int acc_cyc);
        exp_t x;
        acc_cyc = 0;
        if (push) begin
            for (int i = 0; i < DIM; i++) begin
                x.d    = M'(e[i]);
                x.last = (i == DIM - 1);
                x.sat  = s[i];
                sb.push_back(x);
            end
        end
        for (int i = 0; i < DIM; i++) begin
            int t = 0;
            do begin
                @(posedge clk); #1;
                bus.in_valid = 1'b1;
                bus.in_data  = W'(v[i]);
                t++;
            end while (!bus.in_ready && t < 200);
            if (!bus.in_ready) begin
                checks++;
                $display("FAIL input_accept: component %0d not accepted, in_ready stayed 0", i);
            end
            acc_cyc = cyc;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        int t = 0;
        while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        c = cyc;
        if (!bus.out_valid) begin
            checks++;
            $display("FAIL out_valid_timeout: got out_valid=0, expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || bus.out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got out_data %0d, expected none", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", bus.out_data, e.d);
                    check("out_last", bus.out_last, e.last);
                    check("sat_flag", bus.sat_flag, e.sat);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ja, jo;
        bus.matrix_in   = '0;
        bus.matrix_load = 1'b0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sat_flag", bus.sat_flag, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);

        // Identity pass-through and first-output latency
        send('{5, -3, 100, 1}, '{5, -3, 100, 1}, '{0, 0, 0, 0}, 1'b1, ja);
        wait_out(jo);
        check("latency_cycles", jo - ja, 17);
        check("busy_in_emit", bus.busy, 1);
        drain();
        check("idle_busy", bus.busy, 0);

        // All elements 1.0: every output is the component sum
        load_mat(diag_mat(128, 128));
        send('{1, 2, 3, 4}, '{10, 10, 10, 10}, '{0, 0, 0, 0}, 1'b1, ja);
        drain();

        // Diagonal 4.0: saturation at both rails, exact -1024 unclamped
        load_mat(diag_mat(512, 0));
        send('{600, -600, 255, -256}, '{1023, -1024, 1020, -1024}, '{1, 1, 0, 0}, 1'b1, ja);
        drain();

        // Backpressure on component 1
        load_mat(diag_mat(128, 0));
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send('{7, 8, 9, 10}, '{7, 8, 9, 10}, '{0, 0, 0, 0}, 1'b1, ja);
        wait_out(jo);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_data", bus.out_data, 8);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        drain();

        // Diagonal 0.5: rounding vs truncation
        load_mat(diag_mat(64, 0));
`ifdef VTX_ROUND_EN
        send('{3, -3, 1, -1}, '{2, -1, 1, 0}, '{0, 0, 0, 0}, 1'b1, ja);
`else
        send('{3, -3, 1, -1}, '{1, -2, 0, -1}, '{0, 0, 0, 0}, 1'b1, ja);
`endif
        drain();

        // Load during EMIT: vertex in flight keeps identity, next vertex sees new matrix
        load_mat(diag_mat(128, 0));
        send('{2, 3, 4, 5}, '{2, 3, 4, 5}, '{0, 0, 0, 0}, 1'b1, ja);
        wait_out(jo);
        @(posedge clk); #1;
        check("load_during_emit", bus.out_valid, 1);
        bus.matrix_in   = diag_mat(128, 128);
        bus.matrix_load = 1'b1;
        @(posedge clk); #1 bus.matrix_load = 1'b0;
        drain();
        send('{1, 1, 1, 1}, '{4, 4, 4, 4}, '{0, 0, 0, 0}, 1'b1, ja);
        drain();

        // Reset mid-COMPUTE discards the vertex and restores identity
        send('{1, 2, 3, 4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, ja);
        repeat (4) @(posedge clk);
        #1;
        check("mid_compute_busy", bus.busy, 1);
        reset = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("post_rst_in_ready", bus.in_ready, 1);
        send('{9, -9, 0, 1}, '{9, -9, 0, 1}, '{0, 0, 0, 0}, 1'b1, ja);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/vertex_transform_stream.md
Name: vertex_transform_stream

Overview:
Streaming 4x4 (parametrised DIM x DIM) fixed-point matrix-vector transform engine, the next generation of vertex_processor_rtl. It accepts vertex components serially over a ready/valid input, runs a single time-multiplexed MAC, and emits saturated integer components over a ready/valid output with backpressure. The matrix is double-buffered so updates never corrupt a vertex in flight. It sits between the vertex fetch stream and the rasteriser setup stage.

Parameters:
M, 11, integer bits of output component and of matrix elements.
N, 7, fraction bits of matrix elements (1.0 = 2^N = 128).
DIM, 4, vector length and matrix dimension (2..8).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
matrix_in  in  DIM*DIM*(M+N)  signed row-major matrix; element [r][c] at bits (r*DIM+c)*(M+N) +: (M+N).
matrix_load  in  1  one-cycle strobe; captures matrix_in into shadow register.
in_data  in  M+N  signed integer component.
in_valid  in  1  input component valid.
in_ready  out  1  block accepts in_data.
out_data  out  M  signed transformed component.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
out_last  out  1  high with component DIM-1 of each vertex.
sat_flag  out  1  current out_data was clamped.
busy  out  1  high in COMPUTE or EMIT.

Behaviour:
- Reset (reset=0, async): state COLLECT, counters 0, in_ready=1 once released, out_valid=0, out_data=0, out_last=0, sat_flag=0, busy=0, active and shadow matrix = identity (2^N on diagonal, 0 elsewhere), pending flag 0. A partial vertex or in-flight result is discarded.
- States: COLLECT -> COMPUTE -> EMIT -> COLLECT.
- COLLECT: in_ready=1. Each in_valid&&in_ready stores the component at index cnt, then cnt++. After DIM accepts, go to COMPUTE with cnt=0.
- COMPUTE: in_ready=0, busy=1. One MAC per cycle over (r,c) in row-major order, DIM*DIM cycles. Each row's accumulator is cleared at c=0 and its result is written at c=DIM-1.
- EMIT: out_valid=1, out_data=result[k], out_last=(k==DIM-1). Advance k on out_valid&&out_ready. out_data, out_last and sat_flag hold stable while stalled. After the DIM-1 handshake go to COLLECT with out_valid=0 on the next cycle.
- Latency: first out_valid is asserted DIM*DIM+1 cycles after the cycle that accepts the last input component (17 for DIM=4). Throughput is one vertex per 2*DIM+DIM*DIM cycles with no stall.
- Arithmetic: product is 2(M+N) bits signed. Accumulator is 2(M+N)+clog2(DIM) bits and never overflows. Result = acc >>> N (arithmetic), then saturate to [-2^(M-1), 2^(M-1)-1]. sat_flag=1 when clamped.
- Matrix: matrix_load captures into shadow and sets pending. Shadow is copied to active only in COLLECT with cnt=0 (vertex boundary), pending cleared the same cycle. If matrix_load coincides with a boundary copy, the new value is captured and stays pending. Multiple loads before a boundary: the last one wins. A vertex always uses a single matrix.
- in_valid outside COLLECT is ignored, and data is not consumed. out_ready while out_valid=0 has no effect.
- Collect and emit never overlap.

Optional Feature:
VTX_ROUND_EN
- Defined: 2^(N-1) is added to acc before the >>> N shift (round half toward +inf), then saturate.
- Undefined: plain truncation (floor).
- Ports and latency are identical in both builds.

Test Plan:
- Reset, then vertex (5,-3,100,1) with identity matrix -> out 5,-3,100,1; out_last only on 1; first out_valid 17 cycles after last accept; sat_flag=0.
- matrix_load all elements 128, then vertex (1,2,3,4) -> out 10,10,10,10.
- Diagonal 512 (4.0): vertex (600,-600,255,-256) -> out 1023 (sat_flag=1), -1024 (sat_flag=1), 1020 (0), -1024 (0).
- Backpressure: identity, vertex (7,8,9,10), out_ready=0 for 5 cycles on component 1 -> out_data=8 stable, in_ready=0 throughout, all four delivered in order, none lost or duplicated.
- Diagonal 64 (0.5): vertex (3,-3,1,-1) -> with VTX_ROUND_EN 2,-1,1,0; without 1,-2,0,-1.
- matrix_load (all 128) during EMIT of vertex A -> A still identity result, next vertex uses new matrix. Then reset asserted mid-COMPUTE -> out_valid=0, busy=0 immediately; after release in_ready=1 and identity matrix active.
